// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: command port in, one AHB transfer out, response strobe back.
// Latency accept->rsp_valid is 3 cycles at zero wait; cmd_ready is low from accept until the FSM is back in IDLE.
module ahb_lite_master #(
    parameter logic [31:0] APB_BASE  = 32'h0000_0000,
    parameter logic [31:0] APB_MASK  = 32'hFFFF_F000,
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZES,
    output logic [2:0]  HBURST,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic        HSELABPif,
    output logic        HREADYin,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    input  logic [31:0] HRDATA
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_wdata, w_wdata;
    logic [RW-1:0] r_retry, w_retry;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic [1:0]    w_htrans;
    logic          w_hsel, w_hwrite;
    logic [31:0]   w_haddr, w_hwdata;
    logic          w_rsp_valid, w_rsp_err, w_rsp_to;
    logic [31:0]   w_rsp_rdata;
    logic          w_hit, w_to_hit, w_can_retry;

    assign HSIZES   = 3'b010;
    assign HBURST   = 3'b000;
    assign HREADYin = HREADY;

    assign w_hit       = (cmd_addr & APB_MASK) == APB_BASE;
    assign w_to_hit    = (r_to_cnt + TW'(1)) == TW'(TIMEOUT);
    assign w_can_retry = r_retry < RW'(MAX_RETRY);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid && w_hit) w_next = S_ADDR;
            S_ADDR:  if (HREADY) w_next = S_DATA;
            S_DATA: begin
                if (!HREADY) begin
                    if (w_to_hit) w_next = S_DRAIN;
                end else if (HRESP == RSP_OKAY || HRESP == RSP_ERROR || !w_can_retry) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ADDR;
                end
            end
            S_DRAIN: if (HREADY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Computes next values of every registered output; the register bank below just captures them.
    always_comb begin
        cmd_ready   = 1'b0;
        w_htrans    = HTRANS;
        w_hsel      = HSELABPif;
        w_haddr     = HADDR;
        w_hwrite    = HWRITE;
        w_hwdata    = HWDATA;
        w_wdata     = r_wdata;
        w_retry     = r_retry;
        w_to_cnt    = r_to_cnt;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_to    = 1'b0;
        w_rsp_rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_hit) begin
                        w_htrans = TR_NONSEQ;
                        w_hsel   = 1'b1;
                        w_haddr  = cmd_addr;
                        w_hwrite = cmd_write;
                        w_wdata  = cmd_wdata;
                        w_retry  = '0;
                    end else begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    w_htrans = TR_IDLE;
                    w_hsel   = 1'b0;
                    w_to_cnt = '0;
                    if (HWRITE) w_hwdata = r_wdata;
                end
            end
            S_DATA: begin
                if (!HREADY) begin
                    w_to_cnt = r_to_cnt + TW'(1);
                    if (w_to_hit) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_to    = 1'b1;
                    end
                end else if (HRESP == RSP_OKAY) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = HWRITE ? 32'd0 : HRDATA;
                end else if (HRESP == RSP_ERROR || !w_can_retry) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_retry  = r_retry + RW'(1);
                    w_htrans = TR_NONSEQ;
                    w_hsel   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HTRANS      <= TR_IDLE;
            HSELABPif   <= 1'b0;
            HADDR       <= 32'd0;
            HWRITE      <= 1'b0;
            HWDATA      <= 32'd0;
            r_wdata     <= 32'd0;
            r_retry     <= '0;
            r_to_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'd0;
        end else begin
            HTRANS      <= w_htrans;
            HSELABPif   <= w_hsel;
            HADDR       <= w_haddr;
            HWRITE      <= w_hwrite;
            HWDATA      <= w_hwdata;
            r_wdata     <= w_wdata;
            r_retry     <= w_retry;
            r_to_cnt    <= w_to_cnt;
            rsp_valid   <= w_rsp_valid;
            rsp_err     <= w_rsp_err;
            rsp_timeout <= w_rsp_to;
            rsp_rdata   <= w_rsp_rdata;
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: scripted reactive AHB slave plus a transaction-level timing/result model.
module tb_ahb_lite_master;
    localparam int TIMEOUT   = 256;
    localparam int MAX_RETRY = 4;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  HTRANS;
    logic        HWRITE, HSELABPif, HREADYin;
    logic [2:0]  HSIZES, HBURST;
    logic [31:0] HADDR, HWDATA;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [31:0] HRDATA = 32'd0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZES(HSIZES), .HBURST(HBURST),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSELABPif(HSELABPif), .HREADYin(HREADYin),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    typedef struct { int waits; logic [1:0] resp; logic [31:0] rdata; } att_t;
    typedef struct { int cyc; logic err; logic to; logic [31:0] rdata; } rsp_t;

    att_t        script_q[$];
    rsp_t        rsp_q[$];
    att_t        plan[8];
    att_t        cur;
    int          cyc = 0, n_addr = 0, errors = 0, checks = 0, p = 0;
    logic        act = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
    logic        exp_write = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge HCLK) cyc++;

    // Slave: each address phase pops one attempt script (waits, final response, read data).
    always @(negedge HCLK) begin
        if (!HRESETn) act = 1'b0;
        if (act) begin
            chk("data_haddr_stable", HADDR, exp_addr);
            if (p == 0) begin
                chk("data_htrans_idle", 32'(HTRANS), 32'd0);
                chk("data_hsel_low", 32'(HSELABPif), 32'd0);
                if (exp_write) chk("data_hwdata", HWDATA, exp_wdata);
            end
            if (p < cur.waits) begin
                HREADY = 1'b0; HRESP = OKAY; HRDATA = $urandom;
            end else if (cur.resp == OKAY) begin
                HREADY = 1'b1; HRESP = OKAY; HRDATA = cur.rdata; act = 1'b0;
            end else if (p == cur.waits) begin
                HREADY = 1'b0; HRESP = cur.resp; HRDATA = $urandom;
            end else begin
                HREADY = 1'b1; HRESP = cur.resp; HRDATA = $urandom; act = 1'b0;
            end
            p++;
        end else begin
            HREADY = 1'b1; HRESP = OKAY; HRDATA = $urandom;
        end
        if (HRESETn && HTRANS == 2'b10 && HSELABPif) begin
            n_addr++;
            chk("addr_haddr", HADDR, exp_addr);
            chk("addr_hwrite", 32'(HWRITE), 32'(exp_write));
            if (script_q.size() > 0) cur = script_q.pop_front();
            else cur = '{0, OKAY, 32'd0};
            p = 0;
            act = 1'b1;
        end
    end

    always @(negedge HCLK) if (rsp_valid) rsp_q.push_back('{cyc, rsp_err, rsp_timeout, rsp_rdata});

    task automatic tick();
        @(negedge HCLK); #1;
    endtask

    // Model: accept at N, address phase at N+1, each attempt costs 1 + data-phase length cycles.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int nat, output int acc);
        int delta, used, low, b;
        int n0;
        logic err, to, hit;
        logic [31:0] rd;
        rsp_t r;
        hit = (addr & 32'hFFFF_F000) == 32'h0000_0000;
        delta = 1; used = 0; err = 1'b0; to = 1'b0; rd = 32'd0;
        if (!hit) err = 1'b1;
        else begin
            for (int a = 0; a < nat; a++) begin
                used = a + 1;
                low = plan[a].waits + ((plan[a].resp == OKAY) ? 0 : 1);
                if (low >= TIMEOUT) begin
                    delta += 1 + TIMEOUT; err = 1'b1; to = 1'b1; break;
                end
                delta += low + 2;
                if (plan[a].resp == OKAY) begin rd = wr ? 32'd0 : plan[a].rdata; break; end
                if (plan[a].resp == ERROR) begin err = 1'b1; break; end
                if (a == MAX_RETRY) begin err = 1'b1; break; end
            end
        end
        for (int a = 0; a < used; a++) script_q.push_back(plan[a]);
        exp_addr = addr; exp_write = wr; exp_wdata = wdata;
        b = 0;
        while (!cmd_ready && b < 1000) begin tick(); b++; end
        chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        n0 = n_addr;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        acc = cyc;
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom;
        chk("htrans_at_n1", 32'(HTRANS), hit ? 32'd2 : 32'd0);
        chk("cmd_ready_busy_n1", 32'(cmd_ready), hit ? 32'd0 : 32'd1);
        b = 0;
        while (rsp_q.size() == 0 && b < 2000) begin tick(); b++; end
        chk("rsp_seen", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            chk("rsp_cycle", 32'(r.cyc - acc), 32'(delta));
            chk("rsp_err", 32'(r.err), 32'(err));
            chk("rsp_timeout", 32'(r.to), 32'(to));
            chk("rsp_rdata", r.rdata, rd);
        end
        chk("addr_phases", 32'(n_addr - n0), 32'(used));
    endtask

    initial begin
        int acc, b;
        logic [31:0] a;
        repeat (3) tick();
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hsel", 32'(HSELABPif), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_rsp", {28'd0, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 32'd1);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("hsize_hburst", {26'd0, HSIZES, HBURST}, 32'h10);
        HRESETn = 1'b1;
        tick();

        plan[0] = '{0, OKAY, 32'd0};
        run_txn(32'h0000_0004, 1'b1, 32'h0000_00A5, 1, acc);
        plan[0] = '{3, OKAY, 32'h0000_005A};
        run_txn(32'h0000_0008, 1'b0, 32'd0, 1, acc);
        chk("hwdata_hold_after_read", HWDATA, 32'h0000_00A5);
        chk("hreadyin_follows", 32'(HREADYin), 32'(HREADY));
        run_txn(32'h0000_2000, 1'b1, 32'h1234_5678, 0, acc);

        plan[0] = '{0, RETRY, 0}; plan[1] = '{0, SPLIT, 0}; plan[2] = '{0, RETRY, 0};
        plan[3] = '{1, OKAY, 32'hCAFE_F00D};
        run_txn(32'h0000_0010, 1'b0, 32'd0, 4, acc);
        for (int i = 0; i < 5; i++) plan[i] = '{0, RETRY, 0};
        run_txn(32'h0000_0014, 1'b1, 32'h0BAD_BEEF, 5, acc);
        plan[0] = '{2, ERROR, 0};
        run_txn(32'h0000_0018, 1'b0, 32'd0, 1, acc);

        plan[0] = '{300, OKAY, 32'h1111_2222};
        run_txn(32'h0000_001C, 1'b0, 32'd0, 1, acc);
        chk("drain_cmd_ready_low", 32'(cmd_ready), 32'd0);
        b = 0;
        while (!cmd_ready && b < 1000) begin tick(); b++; end
        chk("drain_release_cycle", 32'(cyc - acc), 32'(3 + 300));
        chk("drain_no_extra_rsp", 32'(rsp_q.size()), 32'd0);

        plan[0] = '{50, OKAY, 32'h3333_4444};
        script_q.push_back(plan[0]);
        exp_addr = 32'h0000_0020; exp_write = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_htrans", 32'(HTRANS), 32'd0);
        chk("mid_rst_hsel", 32'(HSELABPif), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        HRESETn = 1'b1;
        repeat (60) tick();
        chk("mid_rst_no_rsp", 32'(rsp_q.size()), 32'd0);
        script_q.delete();

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) a = (32'($urandom_range(1, 32'hFFFFF)) << 12) | {20'd0, 10'($urandom), 2'b00};
            else a = {20'd0, 10'($urandom), 2'b00};
            for (int i = 0; i <= MAX_RETRY; i++) begin
                case ($urandom_range(0, 9))
                    6:       plan[i].resp = ERROR;
                    7, 8:    plan[i].resp = RETRY;
                    9:       plan[i].resp = SPLIT;
                    default: plan[i].resp = OKAY;
                endcase
                plan[i].waits = $urandom_range(0, 4);
                plan[i].rdata = $urandom;
            end
            run_txn(a, 1'($urandom), $urandom, MAX_RETRY + 1, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
